anc_fir_sequencer: RTL and testbench
====================================

Name: anc_fir_sequencer

Overview:
- Core-side initiator for the adaptive FIR engine. Accepts reference-mic samples and error-mic samples.
- Per reference sample, computes the LMS weight-adjust term from the latest error and issues a one-cycle go to the FIR with stable operands.
- Waits for the FIR's done/out_valid, then saturates the returned anti-noise sample to speaker width.
- Sits between the audio front-end and the FIR; drives its feedforward_in/weight_adjust/go and consumes out_sample/out_valid/done.

Parameters:
- MU, 16'sd3277, signed Q1.15 step size.
- FRAC, 15, fractional bits of MU, matching the FIR's FRAC.
- NEG_ERR, 1, when 1 weight_adjust is negated (descent direction).
- OUT_W, 16, speaker sample width, signed.
- TIMEOUT, 255, maximum cycles waited for fir_done after go.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ref_sample  in  32  signed reference-mic sample
- ref_valid  in  1  one-cycle strobe for ref_sample
- err_sample  in  32  signed error-mic sample
- err_valid  in  1  one-cycle strobe for err_sample
- adapt_en  in  1  0 forces weight_adjust to 0 (freeze weights)
- clr_flags  in  1  clears sticky flags and overrun_cnt
- fir_feedforward  out  32  to FIR feedforward_in
- fir_weight_adjust  out  32  to FIR weight_adjust
- fir_go  out  1  to FIR go, one-cycle pulse
- fir_out_sample  in  32  from FIR out_sample
- fir_out_valid  in  1  from FIR out_valid
- fir_done  in  1  from FIR done
- spk_sample  out  OUT_W  saturated anti-noise sample
- spk_valid  out  1  one-cycle strobe for spk_sample
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky: ref_valid arrived while busy
- overrun_cnt  out  8  dropped-sample count, saturates at 255
- fir_timeout  out  1  sticky: FIR failed to respond

Behaviour:
- Reset: all outputs 0, state IDLE, err latch 0, wait counter 0.
- Err latch: on any cycle with err_valid, err_latch <= err_sample, independent of state. Only the latest error is used.
- States: IDLE, CALC, GO, WAIT.
- IDLE: on ref_valid, latch ref_sample into fir_feedforward and go to CALC. fir_done and fir_out_valid are ignored in IDLE (stale responses produce no spk_valid).
- CALC: compute prod = MU * err_latch as a 48-bit signed value.
  - adj = prod >>> FRAC (arithmetic shift).
  - If NEG_ERR, adj = -adj (negate after the shift).
  - Saturate adj to signed 32 bits.
  - fir_weight_adjust <= (adapt_en ? adj : 0).
  - err_valid arriving in CALC updates the latch but not the value already being registered in this cycle.
  - Go to GO.
- GO: fir_go = 1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT:
  - fir_feedforward and fir_weight_adjust are held stable throughout.
  - Counter increments each cycle.
  - If fir_done (or fir_out_valid) is seen: saturate fir_out_sample to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register it to spk_sample, pulse spk_valid on the next cycle, go to IDLE.
  - Else if counter == TIMEOUT: set fir_timeout, go to IDLE, no spk_valid, spk_sample unchanged.
- Latency: ref_valid at cycle N gives fir_go at N+2. spk_valid is one cycle after fir_done.
- Overrun: ref_valid while busy sets overrun and increments overrun_cnt (saturating). The sample is dropped and FIR operands are untouched.
- clr_flags: clears overrun, overrun_cnt and fir_timeout. If it coincides with a new overrun event, the new event wins (flag = 1, cnt = 1).
- spk_sample holds its last value between strobes.
- Asynchronous reset mid-WAIT returns to IDLE immediately. A later fir_done from the FIR is ignored.

Test Plan:
- Basic: err_valid with err=32767, then ref_valid with ref=1000, adapt_en=1 -> fir_go at +2 cycles, fir_feedforward=1000, fir_weight_adjust=-3276. FIR model returns done+out_sample=1234 after 131 cycles -> spk_valid one cycle later, spk_sample=1234, busy low afterwards.
- Adaptation freeze: same stimulus with adapt_en=0 -> fir_weight_adjust=0, fir_feedforward=1000, normal completion.
- Saturation: fir_out_sample=40000 -> spk_sample=32767. fir_out_sample=-40000 -> spk_sample=-32768. fir_out_sample=-5 -> spk_sample=-5.
- Overrun: three ref_valid pulses during WAIT -> overrun=1, overrun_cnt=3, FIR operands unchanged. clr_flags -> both clear.
- Timeout: FIR model never asserts done -> fir_timeout=1 exactly 255 cycles into WAIT, state IDLE, no spk_valid. A following ref_valid starts a normal transaction.
- Reset/stale: assert rst_n low mid-WAIT, release, then inject fir_done with out_sample=777 -> no spk_valid, spk_sample=0, all flags 0.

Source files
------------

// File: rtl/anc_fir_sequencer.sv
// Core-side initiator for the adaptive FIR engine: latches reference/error samples,
// forms the LMS weight-adjust term, strobes the FIR and saturates its reply for the speaker.
module anc_fir_sequencer #(
  parameter logic signed [15:0] MU      = 16'sd3277,
  parameter int                 FRAC    = 15,
  parameter int                 NEG_ERR = 1,
  parameter int                 OUT_W   = 16,
  parameter int                 TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [31:0]      ref_sample,
  input  logic                    ref_valid,
  input  logic signed [31:0]      err_sample,
  input  logic                    err_valid,
  input  logic                    adapt_en,
  input  logic                    clr_flags,
  output logic signed [31:0]      fir_feedforward,
  output logic signed [31:0]      fir_weight_adjust,
  output logic                    fir_go,
  input  logic signed [31:0]      fir_out_sample,
  input  logic                    fir_out_valid,
  input  logic                    fir_done,
  output logic signed [OUT_W-1:0] spk_sample,
  output logic                    spk_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              overrun_cnt,
  output logic                    fir_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CALC, GO, WAIT} state_t;

  state_t                  state_q, state_d;
  logic signed [31:0]      err_q, err_d;
  logic signed [31:0]      ff_q, ff_d;
  logic signed [31:0]      wadj_q, wadj_d;
  logic signed [OUT_W-1:0] spk_q, spk_d;
  logic                    spk_vld_q, spk_vld_d;
  logic                    ovr_q, ovr_d;
  logic [7:0]              ovr_cnt_q, ovr_cnt_d;
  logic                    tmo_q, tmo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [47:0]      prod;
  logic signed [48:0]      adj;

  function automatic logic signed [31:0] sat32(input logic signed [48:0] v);
    logic signed [48:0] hi, lo;
    hi = 49'sd2147483647;
    lo = -49'sd2147483648;
    if (v > hi)      sat32 = 32'sh7FFF_FFFF;
    else if (v < lo) sat32 = 32'sh8000_0000;
    else             sat32 = v[31:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [31:0] v);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (OUT_W - 1));
    if (v > hi)      sat_out = hi[OUT_W-1:0];
    else if (v < lo) sat_out = lo[OUT_W-1:0];
    else             sat_out = v[OUT_W-1:0];
  endfunction

  // Negation happens after the shift, so -(floor(x)) rather than floor(-x).
  always_comb begin
    prod = 48'(MU) * 48'(err_q);
    adj  = 49'(prod >>> FRAC);
    if (NEG_ERR != 0) adj = -adj;
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_valid ? err_sample : err_q;
    ff_d      = ff_q;
    wadj_d    = wadj_q;
    spk_d     = spk_q;
    spk_vld_d = 1'b0;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    fir_go    = 1'b0;

    if (clr_flags) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = 8'd0;
      tmo_d     = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ref_valid) begin
          ff_d    = ref_sample;
          state_d = CALC;
        end
      end
      CALC: begin
        wadj_d  = adapt_en ? sat32(adj) : 32'sd0;
        state_d = GO;
      end
      GO: begin
        fir_go  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fir_done || fir_out_valid) begin
          spk_d     = sat_out(fir_out_sample);
          spk_vld_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A dropped sample overrides a simultaneous clear.
    if (ref_valid && (state_q != IDLE)) begin
      ovr_d = 1'b1;
      if (clr_flags)               ovr_cnt_d = 8'd1;
      else if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      err_q     <= '0;
      ff_q      <= '0;
      wadj_q    <= '0;
      spk_q     <= '0;
      spk_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
      wadj_q    <= wadj_d;
      spk_q     <= spk_d;
      spk_vld_q <= spk_vld_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fir_feedforward   = ff_q;
  assign fir_weight_adjust = wadj_q;
  assign spk_sample        = spk_q;
  assign spk_valid         = spk_vld_q;
  assign busy              = (state_q != IDLE);
  assign overrun           = ovr_q;
  assign overrun_cnt       = ovr_cnt_q;
  assign fir_timeout       = tmo_q;

endmodule

// File: tb/tb_anc_fir_sequencer.sv
// Scoreboard bench for anc_fir_sequencer: directed transactions push expected speaker
// samples; a negedge monitor pops and compares whenever spk_valid is presented.
module tb_anc_fir_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] ref_sample = '0;
  logic               ref_valid = 1'b0;
  logic signed [31:0] err_sample = '0;
  logic               err_valid = 1'b0;
  logic               adapt_en = 1'b0;
  logic               clr_flags = 1'b0;
  logic signed [31:0] fir_feedforward;
  logic signed [31:0] fir_weight_adjust;
  logic               fir_go;
  logic signed [31:0] fir_out_sample = '0;
  logic               fir_out_valid = 1'b0;
  logic               fir_done = 1'b0;
  logic signed [15:0] spk_sample;
  logic               spk_valid;
  logic               busy;
  logic               overrun;
  logic [7:0]         overrun_cnt;
  logic               fir_timeout;

  int tests = 0;
  int fails = 0;
  logic signed [15:0] exp_q[$];

  anc_fir_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ref_sample(ref_sample), .ref_valid(ref_valid),
    .err_sample(err_sample), .err_valid(err_valid),
    .adapt_en(adapt_en), .clr_flags(clr_flags),
    .fir_feedforward(fir_feedforward), .fir_weight_adjust(fir_weight_adjust),
    .fir_go(fir_go), .fir_out_sample(fir_out_sample),
    .fir_out_valid(fir_out_valid), .fir_done(fir_done),
    .spk_sample(spk_sample), .spk_valid(spk_valid), .busy(busy),
    .overrun(overrun), .overrun_cnt(overrun_cnt), .fir_timeout(fir_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && spk_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spk_unexpected: spk_valid with sample %0d, expected none", spk_sample);
      end else begin
        check("spk_sample", spk_sample, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with a FIR model replying after 'delay' cycles in WAIT.
  task automatic txn(input int ref_v, input int err_v, input bit adapt, input int exp_adj,
                     input int delay, input int out_v, input int exp_spk, input int n_ovr);
    err_sample = err_v; err_valid = 1'b1; adapt_en = adapt;
    tick();
    err_valid = 1'b0; ref_sample = ref_v; ref_valid = 1'b1;
    tick();
    ref_valid = 1'b0;
    check("go_early", fir_go, 0);
    err_sample = 12345; err_valid = 1'b1;
    tick();
    err_valid = 1'b0;
    check("go", fir_go, 1);
    check("feedforward", fir_feedforward, ref_v);
    check("weight_adjust", fir_weight_adjust, exp_adj);
    check("busy_go", busy, 1);
    for (int i = 0; i < delay; i++) begin
      if (i >= 10 && i < 10 + n_ovr) begin
        ref_valid = 1'b1; ref_sample = 5000 + i;
      end else begin
        ref_valid = 1'b0;
      end
      tick();
    end
    ref_valid = 1'b0;
    check("hold_feedforward", fir_feedforward, ref_v);
    check("hold_weight_adjust", fir_weight_adjust, exp_adj);
    check("go_once", fir_go, 0);
    fir_out_sample = out_v; fir_done = 1'b1; fir_out_valid = 1'b1;
    exp_q.push_back(16'(exp_spk));
    tick();
    fir_done = 1'b0; fir_out_valid = 1'b0;
    check("busy_after", busy, 0);
    tick();
    check("spk_hold", spk_sample, exp_spk);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_go", fir_go, 0);
    check("rst_ff", fir_feedforward, 0);
    check("rst_wadj", fir_weight_adjust, 0);
    check("rst_spk", spk_sample, 0);
    check("rst_flags", {overrun, fir_timeout, overrun_cnt}, 0);
    rst_n = 1'b1;
    tick();

    txn(1000, 32767, 1'b1, -3276, 131, 1234, 1234, 0);
    txn(1000, 32767, 1'b0, 0, 20, 2222, 2222, 0);
    txn(-7, -65536, 1'b1, 6554, 20, 40000, 32767, 0);
    txn(42, -1, 1'b1, 1, 20, -40000, -32768, 0);
    txn(8, 65536, 1'b1, -6554, 20, -5, -5, 0);
    check("no_overrun_yet", overrun, 0);

    txn(3000, 100, 1'b1, -10, 20, 300, 300, 3);
    check("overrun", overrun, 1);
    check("overrun_cnt", overrun_cnt, 3);

    // clear coinciding with a fresh overrun: the new event wins
    ref_sample = 100; ref_valid = 1'b1;
    tick();
    ref_sample = 555; clr_flags = 1'b1;
    tick();
    ref_valid = 1'b0; clr_flags = 1'b0;
    check("clr_ovr_flag", overrun, 1);
    check("clr_ovr_cnt", overrun_cnt, 1);
    check("dropped_ff", fir_feedforward, 100);
    repeat (3) tick();
    fir_out_sample = 50; fir_done = 1'b1; exp_q.push_back(16'sd50);
    tick();
    fir_done = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("cleared_ovr", overrun, 0);
    check("cleared_cnt", overrun_cnt, 0);

    // timeout: FIR never replies
    ref_sample = 2000; ref_valid = 1'b1;
    tick();
    ref_valid = 1'b0;
    tick();
    check("to_go", fir_go, 1);
    repeat (256) tick();
    check("to_not_yet", fir_timeout, 0);
    check("to_busy", busy, 1);
    tick();
    check("to_flag", fir_timeout, 1);
    check("to_idle", busy, 0);
    check("to_spk_unchanged", spk_sample, 50);
    repeat (2) tick();
    txn(77, -32768, 1'b1, 3277, 20, 32767, 32767, 0);
    check("to_sticky", fir_timeout, 1);

    // reset mid-WAIT, then a stale response
    ref_sample = 600; ref_valid = 1'b1;
    tick();
    ref_valid = 1'b0;
    repeat (20) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_spk", spk_sample, 0);
    check("arst_ff", fir_feedforward, 0);
    tick();
    rst_n = 1'b1;
    tick();
    fir_out_sample = 777; fir_done = 1'b1; fir_out_valid = 1'b1;
    tick();
    fir_done = 1'b0; fir_out_valid = 1'b0;
    tick();
    check("stale_spk", spk_sample, 0);
    check("stale_busy", busy, 0);
    check("stale_flags", {overrun, fir_timeout, overrun_cnt}, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

endmodule
